// File: rtl/ip4_rtl_spa_opc_if.sv
// -----------------------------------------------------------------------------
// ip4_rtl_spa_opc_if
// Bundles every signal between the operand collector and its three neighbours:
// the issue stage, the register-file read port and the SPA operand port.
//
// Groups
//   issue : flush, iss_valid, iss_ready, iss_op, iss_ra, iss_rmask, iss_imm
//   RF    : rd_en, rd_addr, rd_data (rd_data valid exactly 1 cycle after rd_en)
//   SPA   : spa_valid, spa_ready, spa_op, spa_opnd
//   status: busy
//
// Modports
//   master : the collector (drives iss_ready, rd_*, spa_valid/op/opnd, busy)
//   slave  : the environment (issue stage, RF, SPA)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. The sender holds valid and its payload stable until that transfer,
// and valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
interface ip4_rtl_spa_opc_if #(
   parameter int WORD_W = 32,
   parameter int RF_AW  = 8,
   parameter int OPC_W  = 8
);
   logic                flush;
   logic                iss_valid;
   logic                iss_ready;
   logic [OPC_W-1:0]    iss_op;
   logic [4*RF_AW-1:0]  iss_ra;
   logic [3:0]          iss_rmask;
   logic [WORD_W-1:0]   iss_imm;
   logic                rd_en;
   logic [RF_AW-1:0]    rd_addr;
   logic [WORD_W-1:0]   rd_data;
   logic                spa_valid;
   logic                spa_ready;
   logic [OPC_W-1:0]    spa_op;
   logic [4*WORD_W-1:0] spa_opnd;
   logic                busy;

   modport master (
      input  flush, iss_valid, iss_op, iss_ra, iss_rmask, iss_imm,
      input  rd_data, spa_ready,
      output iss_ready, rd_en, rd_addr, spa_valid, spa_op, spa_opnd, busy
   );

   modport slave (
      output flush, iss_valid, iss_op, iss_ra, iss_rmask, iss_imm,
      output rd_data, spa_ready,
      input  iss_ready, rd_en, rd_addr, spa_valid, spa_op, spa_opnd, busy
   );
endinterface

// File: rtl/ip4_rtl_spa_opc.sv
// -----------------------------------------------------------------------------
// ip4_rtl_spa_opc
// Operand collector for the stream processor array. Accepts one decoded
// instruction from the issue stage, reads its RF-sourced operands one per cycle
// over a single RF read port (lowest pending slot first), fills the remaining
// slots from the immediate, and offers {op, op0..op3} to the SPA.
//
// Ports
//   clk         : core clock
//   rst_n       : asynchronous active-low reset
//   bus         : ip4_rtl_spa_opc_if.master (issue, RF read, SPA, busy)
//   o_dbg_state : current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 ISSUE)
// -----------------------------------------------------------------------------
module ip4_rtl_spa_opc #(
   parameter int WORD_W  = 32,
   parameter int NUM_OPS = 4,
   parameter int RF_AW   = 8,
   parameter int OPC_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   ip4_rtl_spa_opc_if.master             bus,
   output logic [1:0]                    o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [OPC_W-1:0]             r_op;
   logic [NUM_OPS*RF_AW-1:0]     r_ra;
   logic [NUM_OPS-1:0]           r_pend;
   logic [NUM_OPS*WORD_W-1:0]    r_opnd;
   // Slot-index pipe: remembers which slot the previous cycle's read targets.
   logic                         r_cap_vld;
   logic [1:0]                   r_cap_slot;

   logic [1:0]                   w_slot;
   logic                         w_found;
   logic [NUM_OPS-1:0]           w_pend_nxt;
   logic                         w_accept;
   logic                         w_rd_en;
   logic                         w_spa_valid;

   // Lowest pending slot and the pending mask once it has been read.
   always_comb begin
      w_slot  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (r_pend[i] && !w_found) begin
            w_slot  = 2'(i);
            w_found = 1'b1;
         end
      end
      w_pend_nxt = r_pend & ~(NUM_OPS'(1) << w_slot);
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_rd_en     = 1'b0;
      w_spa_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            // flush is ignored here, so a same-cycle instruction still enters.
            if (bus.iss_valid) begin
               w_accept = 1'b1;
               w_next   = (bus.iss_rmask == '0) ? S_ISSUE : S_READ;
            end
         end
         S_READ: begin
            w_rd_en = 1'b1;
            if (bus.flush)               w_next = S_IDLE;
            else if (w_pend_nxt == '0)   w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_next = bus.flush ? S_IDLE : S_ISSUE;
         end
         S_ISSUE: begin
            w_spa_valid = 1'b1;
            // A transfer coinciding with flush still counts as delivered.
            if (bus.flush || bus.spa_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_ra       <= '0;
         r_pend     <= '0;
         r_opnd     <= '0;
         r_cap_vld  <= 1'b0;
         r_cap_slot <= '0;
      end else begin
         r_state    <= w_next;
         // A read issued in a flush cycle is never captured.
         r_cap_vld  <= w_rd_en && !bus.flush;
         r_cap_slot <= w_slot;
         if (w_accept) begin
            r_op   <= bus.iss_op;
            r_ra   <= bus.iss_ra;
            r_pend <= bus.iss_rmask;
            // RF slots are zeroed so nothing from an abandoned instruction survives.
            for (int i = 0; i < NUM_OPS; i++) begin
               r_opnd[i*WORD_W +: WORD_W] <= bus.iss_rmask[i] ? '0 : bus.iss_imm;
            end
         end else begin
            if (r_state == S_READ) r_pend <= w_pend_nxt;
            if (bus.flush && r_state != S_IDLE) r_pend <= '0;
            if (r_cap_vld && !bus.flush) begin
               r_opnd[int'(r_cap_slot)*WORD_W +: WORD_W] <= bus.rd_data;
            end
         end
      end
   end

   assign bus.iss_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = w_rd_en ? r_ra[int'(w_slot)*RF_AW +: RF_AW] : '0;
   assign bus.spa_valid = w_spa_valid;
   assign bus.spa_op    = r_op;
   assign bus.spa_opnd  = r_opnd;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ip4_rtl_spa_opc.sv
// -----------------------------------------------------------------------------
// tb_ip4_rtl_spa_opc
// Directed vectors for the operand collector. A small RF model answers every
// read one cycle later with rf[addr]; when no read is outstanding it drives
// random junk so that a stray capture shows up in the operands.
// -----------------------------------------------------------------------------
module tb_ip4_rtl_spa_opc;
   localparam int W  = 32;
   localparam int AW = 8;
   localparam int OW = 8;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ip4_rtl_spa_opc_if #(.WORD_W(W), .RF_AW(AW), .OPC_W(OW)) bus ();
   logic [1:0] dbg_state;

   ip4_rtl_spa_opc #(.WORD_W(W), .NUM_OPS(4), .RF_AW(AW), .OPC_W(OW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // RF model
   logic [W-1:0]  rf [256];
   logic          pend_en;
   logic [AW-1:0] pend_addr;

   always @(negedge clk) begin
      pend_en   = bus.rd_en;
      pend_addr = bus.rd_addr;
   end

   always @(posedge clk) begin
      #1;
      if (pend_en === 1'b1) bus.rd_data = rf[pend_addr];
      else                  bus.rd_data = $urandom;
   end

   // scoreboard
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for exactly one edge (T); returns in cycle T+1.
   task automatic issue(input logic [7:0] op, input logic [31:0] ra,
                        input logic [3:0] mask, input logic [31:0] imm);
      bus.iss_valid = 1'b1;
      bus.iss_op    = op;
      bus.iss_ra    = ra;
      bus.iss_rmask = mask;
      bus.iss_imm   = imm;
      step();
      bus.iss_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_iss_ready"}, 128'(bus.iss_ready), 128'd1);
      check({pfx, "_rd_en"},     128'(bus.rd_en),     128'd0);
      check({pfx, "_rd_addr"},   128'(bus.rd_addr),   128'd0);
      check({pfx, "_spa_valid"}, 128'(bus.spa_valid), 128'd0);
      check({pfx, "_spa_op"},    128'(bus.spa_op),    128'd0);
      check({pfx, "_spa_opnd"},  bus.spa_opnd,        128'd0);
      check({pfx, "_busy"},      128'(bus.busy),      128'd0);
      check({pfx, "_state"},     128'(dbg_state),     128'd0);
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.iss_valid = 1'b0;
      bus.iss_op    = '0;
      bus.iss_ra    = '0;
      bus.iss_rmask = '0;
      bus.iss_imm   = '0;
      bus.spa_ready = 1'b0;
      bus.rd_data   = '0;

      for (int i = 0; i < 256; i++) rf[i] = 32'hF000_0000 | i;
      for (int i = 0; i < 4; i++)   rf[i] = 32'h100 + i;
      rf[8'h10] = 32'h1111_0010;
      rf[8'h20] = 32'h2222_0020;
      for (int i = 0; i < 4; i++)   rf[8'h50 + i] = 32'h5000_0050 + i;
      rf[8'h60] = 32'h6060_6060;
      rf[8'h61] = 32'h6161_6161;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;
      step();

      // all-immediate instruction: valid at T+1
      issue(8'h11, 32'h0, 4'b0000, 32'h5);
      check("imm_valid", 128'(bus.spa_valid), 128'd1);
      check("imm_opnd",  bus.spa_opnd, {32'h5, 32'h5, 32'h5, 32'h5});
      check("imm_op",    128'(bus.spa_op), 128'h11);
      check("imm_iss_ready", 128'(bus.iss_ready), 128'd0);
      bus.spa_ready = 1'b1;
      step();
      bus.spa_ready = 1'b0;
      check("imm_done_valid", 128'(bus.spa_valid), 128'd0);
      check("imm_done_ready", 128'(bus.iss_ready), 128'd1);

      // four RF reads, then hold the SPA off for 5 cycles
      issue(8'h22, {8'd3, 8'd2, 8'd1, 8'd0}, 4'b1111, 32'hDEAD_0000);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rd4_en%0d", k),   128'(bus.rd_en),     128'd1);
         check($sformatf("rd4_addr%0d", k), 128'(bus.rd_addr),   128'(k));
         check($sformatf("rd4_nv%0d", k),   128'(bus.spa_valid), 128'd0);
         step();
      end
      check("rd4_drain_en",    128'(bus.rd_en),     128'd0);
      check("rd4_drain_state", 128'(dbg_state),     128'd2);
      check("rd4_drain_nv",    128'(bus.spa_valid), 128'd0);
      step();
      check("rd4_valid", 128'(bus.spa_valid), 128'd1);
      check("rd4_opnd",  bus.spa_opnd, {32'h103, 32'h102, 32'h101, 32'h100});
      check("rd4_op",    128'(bus.spa_op), 128'h22);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("hold_valid%0d", k), 128'(bus.spa_valid), 128'd1);
         check($sformatf("hold_opnd%0d", k),  bus.spa_opnd, {32'h103, 32'h102, 32'h101, 32'h100});
         check($sformatf("hold_op%0d", k),    128'(bus.spa_op), 128'h22);
         check($sformatf("hold_rdy%0d", k),   128'(bus.iss_ready), 128'd0);
      end
      bus.spa_ready = 1'b1;
      step();
      bus.spa_ready = 1'b0;
      check("hold_rel_valid", 128'(bus.spa_valid), 128'd0);
      check("hold_rel_ready", 128'(bus.iss_ready), 128'd1);

      // mixed mask 0101 with spa_ready high throughout (ignored until ISSUE)
      bus.spa_ready = 1'b1;
      issue(8'h33, {8'h40, 8'h20, 8'h30, 8'h10}, 4'b0101, 32'hAA);
      check("mix_addr0", 128'(bus.rd_addr), 128'h10);
      step();
      check("mix_addr1", 128'(bus.rd_addr), 128'h20);
      step();
      check("mix_drain_en", 128'(bus.rd_en),     128'd0);
      check("mix_drain_nv", 128'(bus.spa_valid), 128'd0);
      step();
      check("mix_valid", 128'(bus.spa_valid), 128'd1);
      check("mix_opnd",  bus.spa_opnd, {32'hAA, 32'h2222_0020, 32'hAA, 32'h1111_0010});
      step();
      check("mix_done", 128'(bus.spa_valid), 128'd0);
      bus.spa_ready = 1'b0;

      // flush after 2 of 4 reads, then a clean instruction
      issue(8'h44, {8'h53, 8'h52, 8'h51, 8'h50}, 4'b1111, 32'h0);
      check("fl_addr0", 128'(bus.rd_addr), 128'h50);
      step();
      check("fl_addr1", 128'(bus.rd_addr), 128'h51);
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("fl_rd_en", 128'(bus.rd_en),     128'd0);
      check("fl_busy",  128'(bus.busy),      128'd0);
      check("fl_ready", 128'(bus.iss_ready), 128'd1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("fl_nv%0d", k), 128'(bus.spa_valid), 128'd0);
         step();
      end
      issue(8'h55, {8'h00, 8'h61, 8'h60, 8'h00}, 4'b0110, 32'h77);
      check("cl_addr0", 128'(bus.rd_addr), 128'h60);
      step();
      check("cl_addr1", 128'(bus.rd_addr), 128'h61);
      step();
      step();
      check("cl_valid", 128'(bus.spa_valid), 128'd1);
      check("cl_opnd",  bus.spa_opnd, {32'h77, 32'h6161_6161, 32'h6060_6060, 32'h77});
      bus.spa_ready = 1'b1;
      step();
      bus.spa_ready = 1'b0;

      // flush in IDLE does not block acceptance; flush with transfer ends cleanly
      bus.flush = 1'b1;
      issue(8'h66, 32'h0, 4'b0000, 32'h33);
      bus.flush = 1'b0;
      check("fi_valid", 128'(bus.spa_valid), 128'd1);
      check("fi_opnd",  bus.spa_opnd, {32'h33, 32'h33, 32'h33, 32'h33});
      bus.flush     = 1'b1;
      bus.spa_ready = 1'b1;
      step();
      bus.flush     = 1'b0;
      bus.spa_ready = 1'b0;
      check("fx_valid", 128'(bus.spa_valid), 128'd0);
      check("fx_ready", 128'(bus.iss_ready), 128'd1);

      // repeated address is read twice
      issue(8'h77, {8'h00, 8'h00, 8'h10, 8'h10}, 4'b0011, 32'hBB);
      check("rep_addr0", 128'(bus.rd_addr), 128'h10);
      step();
      check("rep_addr1", 128'(bus.rd_addr), 128'h10);
      check("rep_en1",   128'(bus.rd_en),   128'd1);
      step();
      step();
      check("rep_valid", 128'(bus.spa_valid), 128'd1);
      check("rep_opnd",  bus.spa_opnd, {32'hBB, 32'hBB, 32'h1111_0010, 32'h1111_0010});
      bus.spa_ready = 1'b1;
      step();
      bus.spa_ready = 1'b0;

      // asynchronous reset while in DRAIN
      issue(8'h88, {8'h03, 8'h00, 8'h00, 8'h02}, 4'b1001, 32'hCC);
      step();
      step();
      check("rd_state_drain", 128'(dbg_state), 128'd2);
      rst_n = 1'b0;
      #1;
      check_reset_vals("arst");
      step();
      rst_n = 1'b1;
      step();
      check("arst_rel_ready", 128'(bus.iss_ready), 128'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
